// File: rtl/alu_op_issue_if.sv
// Decode-to-execute handshake bundle for alu_op_issue: upstream op fields,
// downstream issued op, plus flush/trapped sideband.
interface alu_op_issue_if #(
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 32
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               ALUOp;
  logic [2:0]               funct3;
  logic                     funct7b5;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     illegal;
  logic [TAG_WIDTH-1:0]     out_tag;
  logic                     trapped;

  modport master (
    output flush, in_valid, ALUOp, funct3, funct7b5, in_tag, out_ready,
    input  in_ready, out_valid, Operation, illegal, out_tag, trapped
  );

  modport slave (
    input  flush, in_valid, ALUOp, funct3, funct7b5, in_tag, out_ready,
    output in_ready, out_valid, Operation, illegal, out_tag, trapped
  );
endinterface

// File: rtl/alu_op_issue.sv
// ALU operation encoder feeding execute through a 2-entry skid buffer.
// Optional sticky trap on illegal issue: define ALU_OP_ISSUE_TRAP_EN.
module alu_op_issue #(
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 32
) (
  input logic         clk,
  input logic         reset_n,
  alu_op_issue_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_BGE  = 4'b1010;
  localparam logic [3:0] OP_BLT  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_ADDI = 4'b1101;
  localparam logic [3:0] OP_SLTI = 4'b1110;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  function automatic logic [3:0] encode(input logic [1:0] alu_op,
                                        input logic [2:0] f3,
                                        input logic       f7b5);
    logic [3:0] op;
    op = OP_ILL;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: begin
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          default: op = OP_ILL;
        endcase
      end
      2'b10: begin
        case (f3)
          3'b000:  op = f7b5 ? OP_SUB : OP_ADD;
          3'b001:  op = f7b5 ? OP_ILL : OP_SLL;
          3'b010:  op = f7b5 ? OP_ILL : OP_SLT;
          3'b100:  op = f7b5 ? OP_ILL : OP_XOR;
          3'b101:  op = f7b5 ? OP_SRA : OP_SRL;
          3'b110:  op = f7b5 ? OP_ILL : OP_OR;
          3'b111:  op = f7b5 ? OP_ILL : OP_AND;
          default: op = OP_ILL;
        endcase
      end
      default: begin
        // funct7b5 is an immediate bit for I-type, so only shifts look at it.
        case (f3)
          3'b000:  op = OP_ADDI;
          3'b001:  op = f7b5 ? OP_ILL : OP_SLL;
          3'b010:  op = OP_SLTI;
          3'b100:  op = OP_XOR;
          3'b101:  op = f7b5 ? OP_SRA : OP_SRL;
          3'b110:  op = OP_OR;
          3'b111:  op = OP_AND;
          default: op = OP_ILL;
        endcase
      end
    endcase
    return op;
  endfunction

  logic [3:0] dec_op;
  logic       dec_ill;

  assign dec_op  = encode(bus.ALUOp, bus.funct3, bus.funct7b5);
  assign dec_ill = (dec_op == OP_ILL);

  logic                     out_valid_q, skid_valid_q, in_ready_q;
  logic [OPCODE_LENGTH-1:0] op_q, skid_op_q;
  logic                     ill_q, skid_ill_q;
  logic [TAG_WIDTH-1:0]     tag_q, skid_tag_q;

  logic accept, issue, run_d;
  logic main_valid_d, skid_valid_d;
  logic load_main_in, load_main_skid, load_skid;

  assign accept = bus.in_valid & in_ready_q;
  assign issue  = out_valid_q & bus.out_ready;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    main_valid_d   = out_valid_q;
    skid_valid_d   = skid_valid_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (skid_valid_q) begin
      // in_ready is low while skid is occupied, so only draining is possible.
      if (issue) begin
        load_main_skid = 1'b1;
        skid_valid_d   = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || bus.out_ready) begin
        load_main_in = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        load_skid    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else if (issue) begin
      main_valid_d = 1'b0;
    end
    if (bus.flush) begin
      main_valid_d   = 1'b0;
      skid_valid_d   = 1'b0;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

`ifdef ALU_OP_ISSUE_TRAP_EN
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  logic [0:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (bus.flush)            state_d = ST_RUN;
    else if (issue && ill_q)  state_d = ST_TRAP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  assign run_d       = (state_d == ST_RUN);
  assign bus.trapped = (state_q == ST_TRAP);
`else
  assign run_d       = 1'b1;
  assign bus.trapped = 1'b0;
`endif

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      op_q         <= '0;
      ill_q        <= 1'b0;
      tag_q        <= '0;
    end else begin
      out_valid_q  <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d && run_d;
      if (load_main_in) begin
        op_q  <= OPCODE_LENGTH'(dec_op);
        ill_q <= dec_ill;
        tag_q <= bus.in_tag;
      end else if (load_main_skid) begin
        op_q  <= skid_op_q;
        ill_q <= skid_ill_q;
        tag_q <= skid_tag_q;
      end
    end
  end

  // NOTE: skid payload has no reset; skid_valid_q qualifies it and it never
  // reaches an output unless valid.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_op_q  <= OPCODE_LENGTH'(dec_op);
      skid_ill_q <= dec_ill;
      skid_tag_q <= bus.in_tag;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.Operation = op_q;
  assign bus.illegal   = ill_q;
  assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: directed cases plus random traffic
// scored against a depth-2 FIFO reference model.
module tb_alu_op_issue;

`ifdef ALU_OP_ISSUE_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  alu_op_issue_if #(.OPCODE_LENGTH(4), .TAG_WIDTH(32)) bus ();

  alu_op_issue #(.OPCODE_LENGTH(4), .TAG_WIDTH(32)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        ill;
    logic [31:0] tag;
  } ent_t;

  ent_t q[$];
  bit   m_trapped = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Opcode from the mnemonic rules of the instruction set.
  function automatic logic [3:0] model_op(input logic [1:0] a, input logic [2:0] f3, input logic f7);
    logic [3:0] r;
    r = 4'hF;
    if (a == 2'b00) r = 4'h2;
    else if (a == 2'b01) begin
      if      (f3 == 3'd0) r = 4'h8;
      else if (f3 == 3'd1) r = 4'h9;
      else if (f3 == 3'd4) r = 4'hB;
      else if (f3 == 3'd5) r = 4'hA;
    end else if (a == 2'b10) begin
      if (f7 && f3 != 3'd0 && f3 != 3'd5) r = 4'hF;
      else if (f3 == 3'd0) r = f7 ? 4'h6 : 4'h2;
      else if (f3 == 3'd1) r = 4'h4;
      else if (f3 == 3'd2) r = 4'hC;
      else if (f3 == 3'd4) r = 4'h3;
      else if (f3 == 3'd5) r = f7 ? 4'h7 : 4'h5;
      else if (f3 == 3'd6) r = 4'h1;
      else if (f3 == 3'd7) r = 4'h0;
    end else begin
      if      (f3 == 3'd0) r = 4'hD;
      else if (f3 == 3'd1) r = f7 ? 4'hF : 4'h4;
      else if (f3 == 3'd2) r = 4'hE;
      else if (f3 == 3'd4) r = 4'h3;
      else if (f3 == 3'd5) r = f7 ? 4'h7 : 4'h5;
      else if (f3 == 3'd6) r = 4'h1;
      else if (f3 == 3'd7) r = 4'h0;
    end
    return r;
  endfunction

  task automatic drive(input bit v, input logic [1:0] a, input logic [2:0] f3, input bit f7,
                       input logic [31:0] tag, input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.ALUOp     = a;
    bus.funct3    = f3;
    bus.funct7b5  = f7;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic compare();
    bit exp_ready;
    exp_ready = (q.size() < 2) && !m_trapped;
    check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    check("in_ready",  64'(bus.in_ready),  64'(exp_ready));
    check("trapped",   64'(bus.trapped),   64'(m_trapped));
    if (q.size() != 0) begin
      check("op",      64'(bus.Operation), 64'(q[0].op));
      check("illegal", 64'(bus.illegal),   64'(q[0].ill));
      check("tag",     64'(bus.out_tag),   64'(q[0].tag));
    end
  endtask

  // One clock: predict the handshake, advance the model, then compare.
  task automatic step();
    ent_t e;
    bit   acc, iss;
    acc   = bus.in_valid && (q.size() < 2) && !m_trapped;
    iss   = (q.size() != 0) && bus.out_ready;
    e.op  = model_op(bus.ALUOp, bus.funct3, bus.funct7b5);
    e.ill = (e.op == 4'hF);
    e.tag = bus.in_tag;
    @(posedge clk);
    if (bus.flush) begin
      q.delete();
      m_trapped = 1'b0;
    end else begin
      if (iss) begin
        if (TRAP_BUILD && q[0].ill) m_trapped = 1'b1;
        void'(q.pop_front());
      end
      if (acc) q.push_back(e);
    end
    #1;
    compare();
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 32'h0, ordy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_op",        64'(bus.Operation), 64'd0);
    check("rst_illegal",   64'(bus.illegal),   64'd0);
    check("rst_tag",       64'(bus.out_tag),   64'd0);
    check("rst_trapped",   64'(bus.trapped),   64'd0);

    // R-type stream at full throughput.
    drive(1'b1, 2'b10, 3'b000, 1'b1, 32'h11, 1'b1, 1'b0); step();
    check("sub_op", 64'(bus.Operation), 64'h6);
    drive(1'b1, 2'b10, 3'b101, 1'b1, 32'h12, 1'b1, 1'b0); step();
    check("sra_op", 64'(bus.Operation), 64'h7);
    drive(1'b1, 2'b10, 3'b111, 1'b0, 32'h13, 1'b1, 1'b0); step();
    check("and_op",  64'(bus.Operation), 64'h0);
    check("and_ill", 64'(bus.illegal),   64'h0);
    idle(1'b1); step();

    // Illegal encodings; each is issued then cleared with a flush.
    drive(1'b1, 2'b01, 3'b010, 1'b0, 32'h21, 1'b0, 1'b0); step();
    check("br_ill_op", 64'(bus.Operation), 64'hF);
    check("br_ill",    64'(bus.illegal),   64'h1);
    idle(1'b1); step();
`ifdef ALU_OP_ISSUE_TRAP_EN
    check("trap_set",   64'(bus.trapped),  64'h1);
    check("trap_ready", 64'(bus.in_ready), 64'h0);
`endif
    drive(1'b0, 2'b00, 3'b000, 1'b0, 32'h0, 1'b1, 1'b1); step();
    check("flush_trapped", 64'(bus.trapped),  64'h0);
    check("flush_ready",   64'(bus.in_ready), 64'h1);
    drive(1'b1, 2'b11, 3'b001, 1'b1, 32'h22, 1'b0, 1'b0); step();
    check("slli_ill_op", 64'(bus.Operation), 64'hF);
    check("slli_ill",    64'(bus.illegal),   64'h1);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 32'h0, 1'b1, 1'b1); step();
    drive(1'b1, 2'b11, 3'b010, 1'b1, 32'h23, 1'b1, 1'b0); step();
    check("slti_op", 64'(bus.Operation), 64'hE);
    idle(1'b1); step();

    // Backpressure fills both entries, then drains in order.
    drive(1'b1, 2'b00, 3'b000, 1'b0, 32'hA, 1'b0, 1'b0); step();
    drive(1'b1, 2'b00, 3'b000, 1'b0, 32'hB, 1'b0, 1'b0); step();
    check("bp_ready", 64'(bus.in_ready), 64'h0);
    check("bp_tag",   64'(bus.out_tag),  64'hA);
    idle(1'b0); step();
    check("bp_hold",  64'(bus.out_tag),  64'hA);
    idle(1'b1); step();
    check("bp_tag_b",   64'(bus.out_tag),  64'hB);
    check("bp_ready_1", 64'(bus.in_ready), 64'h1);
    step();
    check("bp_drained", 64'(bus.out_valid), 64'h0);

    // Flush with both entries full; nothing may come out afterwards.
    drive(1'b1, 2'b00, 3'b000, 1'b0, 32'hA, 1'b0, 1'b0); step();
    drive(1'b1, 2'b00, 3'b000, 1'b0, 32'hB, 1'b0, 1'b0); step();
    drive(1'b1, 2'b00, 3'b000, 1'b0, 32'hC, 1'b0, 1'b1); step();
    check("fl_valid", 64'(bus.out_valid), 64'h0);
    check("fl_ready", 64'(bus.in_ready),  64'h1);
    drive(1'b1, 2'b00, 3'b000, 1'b0, 32'hD, 1'b1, 1'b1); step();
    check("fl_drop", 64'(bus.out_valid), 64'h0);
    idle(1'b1); step(); step();

    // Asynchronous reset mid-transfer.
    drive(1'b1, 2'b10, 3'b000, 1'b1, 32'h55, 1'b0, 1'b0); step();
    check("pre_rst_valid", 64'(bus.out_valid), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'h0);
    check("arst_ready", 64'(bus.in_ready),  64'h1);
    check("arst_op",    64'(bus.Operation), 64'h0);
    q.delete();
    m_trapped = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 2'b11, 3'b000, 1'b0, 32'h66, 1'b0, 1'b0); step();
    check("first_accept", 64'(bus.out_valid), 64'h1);
    check("first_op",     64'(bus.Operation), 64'hD);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), 2'($urandom), 3'($urandom), 1'($urandom),
            $urandom, ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 4));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Encoder/issue stage for the ALU: translates ALUOp/funct3/funct7[5] into the 4-bit ALU Operation code.
- Registers the Operation code, an illegal flag and a sideband tag into the execute stage through a 2-entry valid/ready skid buffer.
- Sits between decode and the ALU. Supports stall (backpressure) and flush.

Parameters:
- OPCODE_LENGTH, 4, width of the Operation code.
- TAG_WIDTH, 32, width of the opaque sideband tag (PC or rd/control bundle) carried alongside the op.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept this cycle
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- in_tag  in  TAG_WIDTH  sideband, passed unchanged
- out_valid  out  1  Operation/tag valid to execute
- out_ready  in  1  execute consumes this cycle
- Operation  out  OPCODE_LENGTH  ALU op code
- illegal  out  1  encoding unsupported
- out_tag  out  TAG_WIDTH  sideband of the issued entry
- trapped  out  1  sticky trap state (feature only; tied 0 otherwise)

Behaviour:
- Op codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, BEQ 1000, BNE 1001, BGE 1010, BLT 1011, SLT 1100, ADDI 1101, SLTI 1110, ILL 1111.
- ALUOp 00: ADD, regardless of funct fields.
- ALUOp 01 (branch): funct3 000→BEQ, 001→BNE, 100→BLT, 101→BGE; all other funct3 values → ILL.
- ALUOp 10 (R-type):
  - funct3 000 → ADD (funct7b5=0) or SUB (funct7b5=1).
  - 001 → SLL; 010 → SLT; 100 → XOR.
  - 101 → SRL (funct7b5=0) or SRA (funct7b5=1).
  - 110 → OR; 111 → AND.
  - 011 (SLTU) → ILL.
  - funct7b5=1 with funct3 not in {000,101} → ILL.
- ALUOp 11 (I-type):
  - funct3 000 → ADDI; 010 → SLTI; 100 → XOR; 110 → OR; 111 → AND.
  - 001 → SLLI (encoded SLL), only if funct7b5=0, else ILL.
  - 101 → SRL (funct7b5=0) or SRA (funct7b5=1).
  - 011 → ILL.
- illegal = 1 exactly when the code is ILL. ILL entries are still issued, so execute sees an ALU result of 0.
- Buffer: a main output register plus one skid register.
  - in_ready is registered and equals !skid_valid.
  - Accept = in_valid & in_ready. Issue = out_valid & out_ready.
  - Accept with main empty, or with main issuing and skid empty: the entry goes to main.
  - Accept while main is held (out_valid & !out_ready): the entry goes to skid, and in_ready drops next cycle.
  - Issue with skid full: skid moves to main, and in_ready rises next cycle.
  - Simultaneous accept and issue with skid empty: main is replaced; no bubble.
- Latency: 1 cycle from accept to out_valid when the buffer is empty. Throughput: 1 op/cycle with out_ready held high.
- Outputs hold stable while out_valid & !out_ready. No entry is lost or duplicated.
- flush: next cycle out_valid=0, skid empty, in_ready=1. Any input accepted in the flush cycle is dropped.
- Reset values (async assert, output regs only): out_valid=0, in_ready=1, Operation=0000, illegal=0, out_tag=0, trapped=0, skid empty.
- Reset mid-transfer drops all entries. First accept is possible on the first clk edge after reset_n deasserts.

Optional Feature:
- Macro: ALU_OP_ISSUE_TRAP_EN.
- With the macro: 2-state FSM, RUN and TRAP.
  - RUN→TRAP when an illegal entry issues (out_valid & out_ready & illegal).
  - In TRAP: trapped=1, in_ready=0, and remaining buffered entries are still drained.
  - TRAP→RUN only on flush or reset.
  - trapped is set the cycle after the illegal issue.
- Without the macro: trapped is constant 0, and illegal entries flow like any other.

Test Plan:
- Reset with reset_n=0 mid-transfer while out_valid=1 → out_valid=0, in_ready=1, Operation=0000 immediately, without waiting for a clk edge.
- Stream ALUOp=10: funct3=000/funct7b5=1, then funct3=101/funct7b5=1, then funct3=111, with out_ready=1 → Operation 0110, 0111, 0000 on consecutive cycles, 1 cycle after each accept, illegal=0.
- ALUOp=01 funct3=010 → Operation=1111, illegal=1. ALUOp=11 funct3=001 funct7b5=1 → 1111, illegal=1. ALUOp=11 funct3=010 → 1110.
- Backpressure:
  - out_ready=0 while accepting tags 0xA, then 0xB → in_ready=0 after the second accept, out_tag holds 0xA.
  - Raise out_ready → 0xA then 0xB issue in order, in_ready=1 again.
- Flush with both registers full → next cycle out_valid=0, in_ready=1; tags 0xA and 0xB are never issued.
- With ALU_OP_ISSUE_TRAP_EN: issue an ILL op → trapped=1 and in_ready=0 the next cycle; flush → trapped=0, in_ready=1.
